// File: rtl/ibex_mem_responder_pkg.sv
// Shared types and constants for the ibex_mem_responder data-bus responder slice.
// Holds the response payload struct, latency bound, LFSR seed and byte-lane merge helper.
package ibex_mem_responder_pkg;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;

  localparam int unsigned MEM_RESP_MAX_LATENCY = 8;
  localparam logic [15:0] MEM_RESP_LFSR_SEED   = 16'hACE1;

  // Replace only the byte lanes selected by be; an all-zero be returns old_w untouched.
  function automatic logic [31:0] mem_resp_be_merge(input logic [31:0] old_w,
                                                    input logic [31:0] new_w,
                                                    input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) begin
        w[8*b +: 8] = new_w[8*b +: 8];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ibex_mem_responder_pipe.sv
// ibex_mem_resp_pipe: valid/payload delay line of depth Latency with synchronous clear.
// Payload stages only load when a valid beat enters, so the output holds its last response.
module ibex_mem_resp_pipe
  import ibex_mem_responder_pkg::*;
#(
  parameter int unsigned Latency = 2
) (
  input  logic      clk_i,
  input  logic      clr_i,
  input  logic      in_valid_i,
  input  mem_resp_t in_resp_i,
  output logic      out_valid_o,
  output logic      retire_o,
  output mem_resp_t out_resp_o
);

  localparam int unsigned Depth = (Latency < 1) ? 1 :
                                  (Latency > MEM_RESP_MAX_LATENCY) ? MEM_RESP_MAX_LATENCY :
                                  Latency;

  logic [Depth-1:0] valid_q, valid_d;
  mem_resp_t        resp_q [Depth];
  mem_resp_t        resp_d [Depth];

  always_comb begin
    valid_d = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      resp_d[i] = resp_q[i];
    end
    valid_d[0] = in_valid_i;
    if (in_valid_i) begin
      resp_d[0] = in_resp_i;
    end
    for (int unsigned i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        resp_d[i] = resp_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        resp_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < Depth; i++) begin
        resp_q[i] <= resp_d[i];
      end
    end
  end

  assign out_valid_o = valid_q[Depth-1];
  assign out_resp_o  = resp_q[Depth-1];
  // High in the cycle before a response becomes visible on out_valid_o.
  assign retire_o    = valid_d[Depth-1];

endmodule

// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder: word-addressed SRAM answering Ibex req/gnt/rvalid requests in order.
// Define IBEX_MEM_RESP_RANDOM_STALL_EN to add LFSR-driven pseudo-random grant stalls.
module ibex_mem_responder
  import ibex_mem_responder_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] AddrBase       = 32'h0010_0000,
  parameter int unsigned Latency        = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        stall_i,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [31:0] MemBytes = 32'(4 * MemWords);
  localparam logic [3:0]  MaxOut   = 4'(MaxOutstanding);

  logic [31:0]     mem_q [MemWords];
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic            gnt;
  logic            stall_lfsr;
  logic            retire;
  logic            rvalid;
  logic [3:0]      cnt_q, cnt_d;
  mem_resp_t       req_resp;
  mem_resp_t       pipe_resp;
  logic            unused_offset;

  // Addresses below AddrBase wrap to large offsets, so one compare covers both bounds.
  assign offset        = data_addr_i - AddrBase;
  assign in_range      = offset < MemBytes;
  assign idx           = offset[IdxW+1:2];
  assign unused_offset = ^{offset[31:IdxW+2], offset[1:0]};

`ifdef IBEX_MEM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= MEM_RESP_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_lfsr = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_lfsr = 1'b0;
`endif

  assign gnt = data_req_i & ~stall_i & ~stall_lfsr & (cnt_q < MaxOut) & ~rst_i;

  always_comb begin
    req_resp = '0;
    if (!in_range) begin
      req_resp.err = 1'b1;
    end else if (!data_we_i) begin
      req_resp.rdata = mem_q[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && in_range) begin
      mem_q[idx] <= mem_resp_be_merge(mem_q[idx], data_wdata_i, data_be_i);
    end
  end

  ibex_mem_resp_pipe #(
    .Latency (Latency)
  ) u_pipe (
    .clk_i       (clk_i),
    .clr_i       (rst_i),
    .in_valid_i  (gnt),
    .in_resp_i   (req_resp),
    .out_valid_o (rvalid),
    .retire_o    (retire),
    .out_resp_o  (pipe_resp)
  );

  // A slot frees at the edge that raises rvalid, which lets MaxOutstanding == Latency
  // sustain one grant per cycle without reusing a slot within a single cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !retire) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!gnt && retire && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid;
  assign data_rdata_o  = pipe_resp.rdata;
  assign data_err_o    = pipe_resp.err;
  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Self-checking bench for ibex_mem_responder against a cycle-indexed transaction model.
// A second instance with MaxOutstanding=1 covers the alternating grant pattern.
module tb_ibex_mem_responder;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned LAT       = 2;
  localparam int unsigned MAXO      = 2;
  localparam logic [31:0] BASE      = 32'h0010_0000;
  localparam logic [31:0] END_ADDR  = BASE + 32'(4 * MEM_WORDS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we, stall;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [3:0]  outst;

  logic        s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;
  logic        s_gnt, s_rvalid, s_err;
  logic [31:0] s_rdata;
  logic [3:0]  s_outst;

  ibex_mem_responder #(
    .MemWords(MEM_WORDS), .AddrBase(BASE), .Latency(LAT), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr),
    .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .data_err_o(err), .stall_i(stall), .outstanding_o(outst)
  );

  ibex_mem_responder #(
    .MemWords(64), .AddrBase(BASE), .Latency(2), .MaxOutstanding(1)
  ) dut_s (
    .clk_i(clk), .rst_i(rst), .data_req_i(s_req), .data_gnt_o(s_gnt), .data_addr_i(s_addr),
    .data_we_i(s_we), .data_be_i(s_be), .data_wdata_i(s_wdata), .data_rvalid_o(s_rvalid),
    .data_rdata_o(s_rdata), .data_err_o(s_err), .stall_i(1'b0), .outstanding_o(s_outst)
  );

  // Reference model: responses keyed by the cycle they must appear in.
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        obs_q[$];
  logic [31:0] mem_m [MEM_WORDS];
  int unsigned grant_cyc[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        last_gnt, last_gnt_exp;
  int unsigned last_out, last_out_exp;

  // A grant in cycle g occupies a slot in cycles g+1 .. g+LAT-1.
  function automatic int unsigned model_outstanding(input int unsigned c);
    int unsigned n = 0;
    foreach (grant_cyc[i]) begin
      if (grant_cyc[i] < c && grant_cyc[i] + LAT > c) n++;
    end
    return n;
  endfunction

  task automatic tick(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic st);
    rsp_t        e;
    logic        inr;
    int unsigned wi;
    req = r; we = w; addr = a; be = b; wdata = d; stall = st;
    @(negedge clk);
    last_out_exp = model_outstanding(cyc);
    last_gnt_exp = r && !st && !rst && (last_out_exp < MAXO);
    last_gnt     = gnt;
    last_out     = int'(outst);
    if (rvalid === 1'b1) obs_q.push_back('{err, rdata, cyc});
    if (gnt === 1'b1) begin
      inr     = (a >= BASE) && (a < END_ADDR);
      wi      = inr ? int'((a - BASE) >> 2) : 0;
      e.err   = !inr;
      e.rdata = (inr && !w) ? mem_m[wi] : 32'h0;
      e.cyc   = cyc + LAT;
      exp_q.push_back(e);
      if (inr && w) begin
        for (int k = 0; k < 4; k++) if (b[k]) mem_m[wi][8*k +: 8] = d[8*k +: 8];
      end
      grant_cyc.push_back(cyc);
    end
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      grant_cyc.delete();
    end
    while (grant_cyc.size() > 0 && grant_cyc[0] + LAT <= cyc) void'(grant_cyc.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset rvalid: got %b expected 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset rdata: got %h expected 00000000", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b expected 0", err); end
    checks++; if (outst !== 4'd0) begin errors++; $display("FAIL reset outstanding: got %0d expected 0", outst); end
    checks++; if (s_rvalid !== 1'b0 || s_outst !== 4'd0) begin
      errors++; $display("FAIL reset small inst: got rvalid=%b outstanding=%0d expected 0/0", s_rvalid, s_outst);
    end
  endtask

  task automatic test_preload;
    rsp_t e, o;
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      tick(1'b1, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom(), 1'b0);
      checks++;
      if (last_gnt !== 1'b1) begin errors++; $display("FAIL preload gnt word %0d: got %b expected 1", i, last_gnt); end
    end
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL preload resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h", o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL preload resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_basic;
    rsp_t        e, o;
    logic [31:0] last_rd;
    last_rd = 32'h0;
    tick(1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    checks++; if (last_gnt !== 1'b1) begin errors++; $display("FAIL basic write gnt: got %b expected 1", last_gnt); end
    tick(1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 1'b0);
    checks++; if (last_gnt !== 1'b1) begin errors++; $display("FAIL basic read gnt: got %b expected 1", last_gnt); end
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; last_rd = o.rdata;
      if (o.cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL basic resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h", o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL basic resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
    checks++; if (last_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic readback: got %h expected deadbeef", last_rd); end
  endtask

  task automatic test_partial;
    rsp_t        e, o;
    logic [31:0] last_rd;
    last_rd = 32'h0;
    tick(1'b1, 1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, 1'b0);
    tick(1'b1, 1'b1, BASE + 32'h20, 4'b0010, 32'h0000_AB00, 1'b0);
    tick(1'b1, 1'b1, BASE + 32'h20, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    tick(1'b1, 1'b0, BASE + 32'h22, 4'h0, 32'h0, 1'b0);
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; last_rd = o.rdata;
      if (o.cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL partial resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h", o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL partial resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
    checks++; if (last_rd !== 32'h1122_AB44) begin errors++; $display("FAIL partial readback: got %h expected 1122ab44", last_rd); end
  endtask

  task automatic test_out_of_range;
    rsp_t        e, o;
    logic [31:0] bad [5];
    bad[0] = END_ADDR; bad[1] = BASE - 32'd4; bad[2] = END_ADDR + 32'h100; bad[3] = 32'h0; bad[4] = 32'hFFFF_FFFC;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, bad[i], 4'h0, 32'h0, 1'b0);
      tick(1'b1, 1'b1, bad[i], 4'hF, 32'hFFFF_FFFF, 1'b0);
    end
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.err !== 1'b1 || o.rdata !== 32'h0 || o.err !== e.err) begin
        errors++;
        $display("FAIL range resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=1 rdata=00000000", o.cyc, o.err, o.rdata, e.cyc);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL range resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_pattern;
    logic [5:0]  gseq;
    int unsigned ng, max_out;
    logic        err_any;
    logic [31:0] rd[$];
    gseq = '0; ng = 0; max_out = 0; err_any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_req = (i < 6); s_we = (ng != 1); s_addr = BASE + 32'h40; s_be = 4'hF;
      s_wdata = 32'h5A5A_0000 + 32'(ng);
      @(negedge clk);
      if (i < 6) gseq[i] = s_gnt;
      if (s_gnt === 1'b1) ng++;
      if (int'(s_outst) > max_out) max_out = int'(s_outst);
      if (s_rvalid === 1'b1) begin rd.push_back(s_rdata); err_any |= s_err; end
      @(posedge clk);
      #1;
    end
    s_req = 1'b0;
    checks++; if (gseq !== 6'b010101) begin errors++; $display("FAIL pattern gnt seq (cycle0=lsb): got %b expected 010101", gseq); end
    checks++; if (max_out > 1) begin errors++; $display("FAIL pattern outstanding: got max %0d expected <= 1", max_out); end
    checks++; if (rd.size() != 3) begin errors++; $display("FAIL pattern resp count: got %0d expected 3", rd.size()); end
    checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL pattern err: got %b expected 0", err_any); end
    if (rd.size() == 3) begin
      checks++;
      if (rd[0] !== 32'h0 || rd[1] !== 32'h5A5A_0000 || rd[2] !== 32'h0) begin
        errors++; $display("FAIL pattern rdata order: got %h %h %h expected 00000000 5a5a0000 00000000", rd[0], rd[1], rd[2]);
      end
    end
  endtask

  task automatic test_stall;
    rsp_t e, o;
    logic st;
    for (int i = 0; i < 10; i++) begin
      st = (i >= 3 && i <= 5);
      tick(1'b1, 1'b0, BASE + 32'($urandom_range(0, MEM_WORDS - 1)) * 32'd4, 4'h0, 32'h0, st);
      checks++;
      if (last_gnt !== last_gnt_exp) begin errors++; $display("FAIL stall gnt cycle %0d: got %b expected %b", i, last_gnt, last_gnt_exp); end
      if (i == 6) begin
        checks++; if (last_gnt !== 1'b1) begin errors++; $display("FAIL stall resume: got %b expected 1", last_gnt); end
      end
    end
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL stall resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h", o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL stall resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_random;
    rsp_t        e, o;
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        a = BASE + 32'($urandom_range(0, MEM_WORDS - 1)) * 32'd4 + 32'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 2))
          0:       a = END_ADDR + 32'($urandom_range(0, 15)) * 32'd4;
          1:       a = BASE - 32'd4 - 32'($urandom_range(0, 15)) * 32'd4;
          default: a = $urandom();
        endcase
      end
      tick($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)),
           $urandom(), $urandom_range(0, 4) == 0);
      checks++;
      if (last_gnt !== last_gnt_exp || last_out !== last_out_exp) begin
        errors++;
        $display("FAIL random gnt/outstanding cycle %0d: got gnt=%b out=%0d expected gnt=%b out=%0d", i, last_gnt, last_out, last_gnt_exp, last_out_exp);
      end
    end
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL random resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h", o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL random resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    rsp_t        e, o;
    int unsigned n_obs;
    logic [31:0] last_rd;
    last_rd = 32'h0;
    tick(1'b1, 1'b1, BASE + 32'h80, 4'hF, 32'hC0FF_EE11, 1'b0);
    tick(1'b1, 1'b0, BASE + 32'h84, 4'h0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, BASE + 32'h88, 4'h0, 32'h0, 1'b0);
    checks++; if (last_gnt !== 1'b1) begin errors++; $display("FAIL rstmid second read gnt: got %b expected 1", last_gnt); end
    rst = 1'b1;
    tick(1'b1, 1'b0, BASE + 32'h8C, 4'h0, 32'h0, 1'b0);
    rst = 1'b0;
    checks++; if (last_gnt !== 1'b0) begin errors++; $display("FAIL rstmid gnt during reset: got %b expected 0", last_gnt); end
    n_obs = obs_q.size();
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (last_out !== 0) begin errors++; $display("FAIL rstmid outstanding cycle %0d: got %0d expected 0", i, last_out); end
    end
    checks++; if (obs_q.size() != n_obs) begin errors++; $display("FAIL rstmid rvalid after reset: got %0d responses expected 0", obs_q.size() - n_obs); end
    tick(1'b1, 1'b0, BASE + 32'h80, 4'h0, 32'h0, 1'b0);
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; last_rd = o.rdata;
      if (o.cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL rstmid resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h", o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL rstmid resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
    checks++; if (last_rd !== 32'hC0FF_EE11) begin errors++; $display("FAIL rstmid readback: got %h expected c0ffee11", last_rd); end
  endtask

  task automatic test_readback;
    rsp_t e, o;
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      tick(1'b1, 1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, 1'b0);
    end
    idle(LAT + 2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL readback resp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h", o.cyc, o.err, o.rdata, e.cyc, e.err, e.rdata);
      end
    end
    checks++;
    if (exp_q.size() != MEM_WORDS - MEM_WORDS || obs_q.size() != 0) begin
      errors++; $display("FAIL readback resp count: got %0d extra expected %0d missing", obs_q.size(), exp_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; stall = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    s_req = 1'b0; s_we = 1'b0; s_be = 4'h0; s_addr = 32'h0; s_wdata = 32'h0;
    test_reset();
    test_preload();
    test_basic();
    test_partial();
    test_out_of_range();
    test_pattern();
    test_stall();
    test_random();
    test_reset_mid();
    test_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
